// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among four
// byte producers. Grants one requester, latches its byte, runs the tx
// Send/Sent four-phase handshake, aborts a silent transmitter through a
// watchdog, and counts successfully sent bytes.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_sent,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  tx_count
);

    // Watchdog only needs to count up to TIMEOUT_CYCLES-1; SEND is left
    // before it could ever wrap.
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [1:0]      last_reg;
    logic [WD_W-1:0] wdog_reg;
    logic [3:0]      grant_reg;
    logic [3:0]      done_reg;
    logic [7:0]      tx_data_reg;
    logic            tx_send_reg;
    logic            busy_reg;
    logic            timeout_err_reg;
    logic [7:0]      tx_count_reg;

    // Candidate indices in round-robin scan order and per-requester bytes.
    logic [1:0] cand  [4];
    logic [7:0] byte_in [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
        assign cand[gi]    = last_reg + 2'(gi + 1);
        assign byte_in[gi] = data_in[8*gi +: 8];
    end

    logic       pick_valid;
    logic [1:0] pick_idx;

    // First requesting index after last_reg wins; scanning backwards lets
    // the earliest candidate overwrite later ones.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[cand[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[k];
            end
        end
    end

    // Arbitration/handshake FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            last_reg        <= 2'd3;
            wdog_reg        <= '0;
            grant_reg       <= 4'b0000;
            done_reg        <= 4'b0000;
            tx_data_reg     <= 8'h00;
            tx_send_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            tx_count_reg    <= 8'h00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 4'b0000;
                    if (pick_valid) begin
                        grant_reg   <= 4'b0001 << pick_idx;
                        last_reg    <= pick_idx;
                        tx_data_reg <= byte_in[pick_idx];
                        tx_send_reg <= 1'b1;
                        wdog_reg    <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= S_SEND;
                    end
                end
                S_SEND: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    if (tx_sent) begin
                        tx_send_reg  <= 1'b0;
                        tx_count_reg <= tx_count_reg + 8'd1;
                        state_reg    <= S_RELEASE;
                    end else if (wdog_reg == WD_LAST) begin
                        tx_send_reg     <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!tx_sent) begin
                        done_reg  <= grant_reg;
                        grant_reg <= 4'b0000;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_reg  <= 4'b0000;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign done        = done_reg;
    assign tx_data     = tx_data_reg;
    assign tx_send     = tx_send_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_err_reg;
    assign tx_count    = tx_count_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table of single transfers plus directed
// sequences for ordering, fairness, data latching, watchdog, reset and wrap.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_sent;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  tx_count;

    int tests = 0;
    int fails = 0;
    int exp_count = 0;

    // Transmitter model knobs
    int sent_delay   = 10;
    int drop_delay   = 2;
    bit never_answer = 1'b0;
    int send_cnt = 0;
    int drop_cnt = 0;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .grant       (grant),
        .done        (done),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_sent     (tx_sent),
        .busy        (busy),
        .timeout_err (timeout_err),
        .tx_count    (tx_count)
    );

    always #5 clk = ~clk;

    // tx model: raises Sent sent_delay cycles after Send, drops it
    // drop_delay cycles after Send falls. Driven on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            tx_sent  = 1'b0;
            send_cnt = 0;
            drop_cnt = 0;
        end else if (tx_send && !tx_sent) begin
            send_cnt++;
            if (!never_answer && send_cnt >= sent_delay) tx_sent = 1'b1;
        end else if (!tx_send && tx_sent) begin
            drop_cnt++;
            if (drop_cnt >= drop_delay) begin
                tx_sent  = 1'b0;
                drop_cnt = 0;
            end
        end else if (!tx_send) begin
            send_cnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
    endtask

    // Waits for grant then done with bounded budgets; drops the granted
    // request bit at the done cycle.
    task automatic wait_xfer(output logic [3:0] g, output logic [7:0] b, output logic [3:0] dn);
        bit seen;
        g = '0; b = '0; dn = '0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant != 4'b0000) begin seen = 1'b1; break; end
        end
        check("grant_wait", 32'(seen), 32'd1);
        if (seen) begin
            g = grant;
            b = tx_data;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (done != 4'b0000) begin seen = 1'b1; break; end
            end
            check("done_wait", 32'(seen), 32'd1);
            dn  = done;
            req = req & ~g;
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [3:0] g;
        logic [7:0] b;
        logic [3:0] dn;
        logic [3:0] order [$];
        logic [7:0] bytes [$];
        logic [7:0] latch_val;
        int         cnt;
        bit         seen;

        // Expected values assume round-robin pointer starts at 3 after reset
        vecs[0] = '{4'b0010, 32'h0000_4100, 4'b0010, 8'h41}; // last=1
        vecs[1] = '{4'b0011, 32'h0000_EE5A, 4'b0001, 8'h5A}; // last=0
        vecs[2] = '{4'b1001, 32'h7E00_0011, 4'b1000, 8'h7E}; // last=3
        vecs[3] = '{4'b0110, 32'h0033_C400, 4'b0010, 8'hC4}; // last=1
        vecs[4] = '{4'b0110, 32'h0033_C400, 4'b0100, 8'h33}; // last=2
        vecs[5] = '{4'b0001, 32'hFFFF_FF00, 4'b0001, 8'h00}; // last=0
        vecs[6] = '{4'b1110, 32'h9A8B_7C6D, 4'b0010, 8'h7C}; // last=1

        rst = 1'b1;
        req = 4'b0000;
        data_in = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_send", 32'(tx_send), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_tx_count", 32'(tx_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single transfers
        for (int v = 0; v < 7; v++) begin
            req = vecs[v].req;
            data_in = vecs[v].data;
            wait_xfer(g, b, dn);
            req = 4'b0000;
            exp_count++;
            check("vec_grant", 32'(g), 32'(vecs[v].exp_grant));
            check("vec_byte", 32'(b), 32'(vecs[v].exp_byte));
            check("vec_done", 32'(dn), 32'(vecs[v].exp_grant));
            check("vec_count", 32'(tx_count), 32'(exp_count));
            check("vec_timeout", 32'(timeout_err), 32'h0);
            @(negedge clk);
            check("vec_done_pulse", 32'(done), 32'h0);
            check("vec_idle_busy", 32'(busy), 32'h0);
            $display("[TB] vec %0d req=%b grant=%b byte=%h count=%0d", v, vecs[v].req, g, b, tx_count);
        end

        // Simultaneous requests
        do_reset();
        data_in = 32'h1312_1110;
        req = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            wait_xfer(g, b, dn);
            order.push_back(g);
            bytes.push_back(b);
            exp_count++;
            $display("[TB] simul %0d grant=%b byte=%h", t, g, b);
        end
        req = 4'b0000;
        for (int t = 0; t < 4; t++) begin
            check("simul_order", 32'(order[t]), 32'(4'b0001 << t));
            check("simul_byte", 32'(bytes[t]), 32'(8'h10 + t));
        end
        check("simul_count", 32'(tx_count), 32'd4);

        // Fairness between requesters 0 and 2
        order.delete();
        data_in = 32'h00C0_00A0;
        req = 4'b0101;
        for (int t = 0; t < 6; t++) begin
            wait_xfer(g, b, dn);
            req = 4'b0101;
            order.push_back(g);
            exp_count++;
            $display("[TB] fair %0d grant=%b", t, g);
        end
        req = 4'b0000;
        for (int t = 0; t < 6; t++)
            check("fair_order", 32'(order[t]), (t % 2 == 0) ? 32'h1 : 32'h4);

        // Data latch: byte changes one cycle after grant
        repeat (3) @(negedge clk);
        data_in = 32'h0000_0055;
        req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant != 4'b0000) begin seen = 1'b1; break; end
        end
        check("latch_grant_wait", 32'(seen), 32'd1);
        latch_val = tx_data;
        @(negedge clk);
        data_in = 32'h0000_00AA;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_data != 8'h55) latch_val = tx_data;
            @(negedge clk);
            if (done != 4'b0000) begin seen = 1'b1; break; end
        end
        req = 4'b0000;
        exp_count++;
        check("latch_done_wait", 32'(seen), 32'd1);
        check("latch_hold", 32'(latch_val), 32'h55);
        $display("[TB] latch byte=%h", latch_val);

        // Watchdog abort
        repeat (3) @(negedge clk);
        never_answer = 1'b1;
        req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant != 4'b0000) begin seen = 1'b1; break; end
        end
        check("wd_grant_wait", 32'(seen), 32'd1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!tx_send) break;
            cnt++;
            @(negedge clk);
        end
        check("wd_send_cycles", 32'(cnt), 32'd20);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done != 4'b0000) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("wd_done_wait", 32'(seen), 32'd1);
        check("wd_done", 32'(done), 32'h1);
        check("wd_timeout_err", 32'(timeout_err), 32'h1);
        check("wd_count", 32'(tx_count), 32'(exp_count));
        req = 4'b0000;
        never_answer = 1'b0;
        $display("[TB] watchdog send_cycles=%0d timeout_err=%b", cnt, timeout_err);
        @(negedge clk);
        req = 4'b1000;
        data_in = 32'h5A00_0000;
        wait_xfer(g, b, dn);
        req = 4'b0000;
        exp_count++;
        check("wd_after_done", 32'(dn), 32'h8);
        check("wd_after_count", 32'(tx_count), 32'(exp_count));
        check("wd_sticky", 32'(timeout_err), 32'h1);

        // Reset while in SEND
        repeat (2) @(negedge clk);
        req = 4'b0100;
        data_in = 32'h0077_0000;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant != 4'b0000) begin seen = 1'b1; break; end
        end
        check("mid_grant_wait", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_tx_send", 32'(tx_send), 32'h0);
        check("mid_grant", 32'(grant), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_timeout_err", 32'(timeout_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        exp_count = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done != 4'b0000) seen = 1'b1;
        end
        check("mid_no_done", 32'(seen), 32'd0);
        check("mid_count", 32'(tx_count), 32'd0);
        $display("[TB] reset mid-send done_seen=%b", seen);

        // 256 transfers wrap tx_count
        do_reset();
        sent_delay = 1;
        drop_delay = 0;
        for (int t = 0; t < 256; t++) begin
            req = 4'b0001 << (t % 4);
            data_in = {4{8'(t)}};
            wait_xfer(g, b, dn);
            req = 4'b0000;
            exp_count = (exp_count + 1) % 256;
            if (t == 254) check("wrap_255", 32'(tx_count), 32'd255);
        end
        check("wrap_zero", 32'(tx_count), 32'd0);
        $display("[TB] wrap count=%0d", tx_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
